// File: rtl/ahb3lite_gpio_slave.sv
// ahb3lite_gpio_slave: AHB3-Lite GPIO responder with LED set/clear registers, synchronized buttons,
// sticky rising-edge capture, ID word, programmable wait states and two-cycle ERROR responses.
// Ports: clk_i/rst_i (HCLK, async active-high reset); hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i,
// hburst_i, hprot_i, hwdata_i, hready_i (AHB inputs); hrdata_o, hreadyout_o, hresp_o (AHB outputs);
// led_o (LED register); btn_i (asynchronous push-button inputs).
module ahb3lite_gpio_slave #(
   parameter int unsigned g_led_width   = 8,
   parameter int unsigned g_btn_width   = 1,
   parameter int unsigned g_wait_states = 0,
   parameter logic [31:0] g_id          = 32'hC0DE_0001
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   hsel_i,
   input  logic [31:0]            haddr_i,
   input  logic [1:0]             htrans_i,
   input  logic                   hwrite_i,
   input  logic [2:0]             hsize_i,
   input  logic [2:0]             hburst_i,
   input  logic [3:0]             hprot_i,
   input  logic [31:0]            hwdata_i,
   input  logic                   hready_i,
   output logic [31:0]            hrdata_o,
   output logic                   hreadyout_o,
   output logic                   hresp_o,
   output logic [g_led_width-1:0] led_o,
   input  logic [g_btn_width-1:0] btn_i
);
   typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
   state_t                 state_q, state_d;
   logic                   accept, illegal, fin, we, pend_q, write_q, unused;
   logic [9:0]             word, addr_q;
   logic [2:0]             cnt_q;
   logic [31:0]            rd_val;
   logic [g_led_width-1:0] led_q, led_d;
   logic [g_btn_width-1:0] sync1_q, sync2_q, sync3_q, edge_q, hw_edge, edge_clr;

   assign unused  = ^{haddr_i[31:12], htrans_i[0], hburst_i, hprot_i, hwdata_i};
   assign word    = haddr_i[11:2];
   // hreadyout_o gate keeps a stalled data phase from accepting a second address
   assign accept  = hsel_i & hready_i & htrans_i[1] & hreadyout_o;
   assign illegal = (hsize_i != 3'b010) | (haddr_i[1:0] != 2'b00) | (word > 10'd5) |
                    (hwrite_i & ((word == 10'd3) | (word == 10'd5)));
   // final OKAY data-phase cycle: a legal transfer is pending and no wait state remains
   assign fin     = (state_q == IDLE) & pend_q;
   assign we      = fin & write_q;
   assign hw_edge = sync2_q & ~sync3_q;
   assign edge_clr = (we && addr_q == 10'd4) ? hwdata_i[g_btn_width-1:0] : '0;
   assign led_d   = (addr_q == 10'd0) ? hwdata_i[g_led_width-1:0] :
                    (addr_q == 10'd1) ? led_q | hwdata_i[g_led_width-1:0] :
                    (addr_q == 10'd2) ? led_q & ~hwdata_i[g_led_width-1:0] : led_q;
   assign rd_val  = (addr_q == 10'd0) ? 32'(led_q) :
                    (addr_q == 10'd3) ? 32'(sync2_q) :
                    (addr_q == 10'd4) ? 32'(edge_q) :
                    (addr_q == 10'd5) ? g_id : 32'd0;
   assign led_o   = led_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else state_q <= state_d;
   end

   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE, ERR2: state_d = !accept ? IDLE : illegal ? ERR1 : (g_wait_states == 0) ? IDLE : WAIT;
         WAIT:       state_d = (cnt_q == 3'd1) ? IDLE : WAIT;
         ERR1:       state_d = ERR2;
         default:    state_d = IDLE;
      endcase
   end

   always_comb begin
      hreadyout_o = (state_q != WAIT) && (state_q != ERR1);
      hresp_o     = (state_q == ERR1) || (state_q == ERR2);
      hrdata_o    = (fin && !write_q) ? rd_val : 32'd0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend_q  <= 1'b0;
         write_q <= 1'b0;
         addr_q  <= '0;
         cnt_q   <= '0;
         led_q   <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
         sync3_q <= '0;
         edge_q  <= '0;
      end else begin
         pend_q  <= accept ? ~illegal : (fin ? 1'b0 : pend_q);
         write_q <= accept ? hwrite_i : write_q;
         addr_q  <= accept ? word : addr_q;
         cnt_q   <= (accept && !illegal) ? 3'(g_wait_states) : (state_q == WAIT) ? cnt_q - 3'd1 : cnt_q;
         led_q   <= we ? led_d : led_q;
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
         // hardware edge wins over a same-cycle W1C of the same bit
         edge_q  <= (edge_q & ~edge_clr) | hw_edge;
      end
   end
endmodule

// File: tb/tb_ahb3lite_gpio_slave.sv
// tb_ahb3lite_gpio_slave: directed self-checking bench for ahb3lite_gpio_slave (0 and 3 wait states)
module tb_ahb3lite_gpio_slave;
   logic        clk = 1'b0, rst = 1'b1;
   logic        hsel0 = 1'b0, hsel3 = 1'b0, hwrite = 1'b0;
   logic [31:0] haddr = '0, hwdata = '0;
   logic [1:0]  htrans = 2'b00;
   logic [2:0]  hsize = 3'b010, hburst = 3'b000;
   logic [3:0]  hprot = 4'b0000;
   logic [0:0]  btn = 1'b0;
   logic [31:0] rdata0, rdata3;
   logic        rdy0, rdy3, resp0, resp3;
   logic [7:0]  led0, led3;
   int          checks = 0, failures = 0;

   always #5 clk = ~clk;

   ahb3lite_gpio_slave dut0 (
      .clk_i(clk), .rst_i(rst), .hsel_i(hsel0), .haddr_i(haddr), .htrans_i(htrans),
      .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(hburst), .hprot_i(hprot), .hwdata_i(hwdata),
      .hready_i(rdy0), .hrdata_o(rdata0), .hreadyout_o(rdy0), .hresp_o(resp0), .led_o(led0), .btn_i(btn)
   );

   ahb3lite_gpio_slave #(.g_wait_states(3)) dut3 (
      .clk_i(clk), .rst_i(rst), .hsel_i(hsel3), .haddr_i(haddr), .htrans_i(htrans),
      .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(hburst), .hprot_i(hprot), .hwdata_i(hwdata),
      .hready_i(rdy3), .hrdata_o(rdata3), .hreadyout_o(rdy3), .hresp_o(resp3), .led_o(led3), .btn_i(btn)
   );

   task automatic ap(input bit s3, input logic [31:0] a, input bit w, input logic [2:0] sz);
      hsel0 = !s3; hsel3 = s3; haddr = a; htrans = 2'b10; hwrite = w; hsize = sz;
   endtask

   task automatic idle();
      hsel0 = 1'b0; hsel3 = 1'b0; htrans = 2'b00; hwrite = 1'b0;
   endtask

   // single non-pipelined transfer; checks wait count, response and (for reads) data
   task automatic xfer(input bit s3, input logic [31:0] a, input bit w, input logic [2:0] sz,
                       input logic [31:0] wd, input logic [31:0] erd, input bit eresp, input int ew,
                       input string nm);
      int waits = 0;
      @(negedge clk);
      ap(s3, a, w, sz);
      @(negedge clk);
      idle();
      hwdata = wd;
      while ((s3 ? rdy3 : rdy0) === 1'b0 && waits < 20) begin
         checks++;
         if ((s3 ? resp3 : resp0) !== eresp) begin
            failures++; $display("FAIL %s stall hresp got=%b exp=%b", nm, s3 ? resp3 : resp0, eresp);
         end
         waits++;
         @(negedge clk);
      end
      checks++;
      if (waits != ew) begin failures++; $display("FAIL %s waits got=%0d exp=%0d", nm, waits, ew); end
      checks++;
      if ((s3 ? resp3 : resp0) !== eresp) begin
         failures++; $display("FAIL %s hresp got=%b exp=%b", nm, s3 ? resp3 : resp0, eresp);
      end
      if (!w) begin
         checks++;
         if ((s3 ? rdata3 : rdata0) !== erd) begin
            failures++; $display("FAIL %s hrdata got=%h exp=%h", nm, s3 ? rdata3 : rdata0, erd);
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({rdy0, resp0, rdata0, led0} !== {1'b1, 1'b0, 32'd0, 8'd0}) begin
         failures++; $display("FAIL reset0 rdy/resp/rdata/led got=%b/%b/%h/%h exp=1/0/0/0", rdy0, resp0, rdata0, led0);
      end
      checks++;
      if ({rdy3, resp3, rdata3, led3} !== {1'b1, 1'b0, 32'd0, 8'd0}) begin
         failures++; $display("FAIL reset3 rdy/resp/rdata/led got=%b/%b/%h/%h exp=1/0/0/0", rdy3, resp3, rdata3, led3);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_id();
      xfer(1'b0, 32'h14, 1'b0, 3'b010, 32'd0, 32'hC0DE0001, 1'b0, 0, "id_read");
   endtask

   task automatic test_back_to_back();
      @(negedge clk); ap(1'b0, 32'h00, 1'b1, 3'b010);
      @(negedge clk); hwdata = 32'hA5; ap(1'b0, 32'h08, 1'b1, 3'b010);
      @(negedge clk);
      checks++;
      if (led0 !== 8'hA5) begin failures++; $display("FAIL b2b_led_write got=%h exp=a5", led0); end
      hwdata = 32'h0F; ap(1'b0, 32'h00, 1'b0, 3'b010);
      @(negedge clk);
      checks++;
      if (led0 !== 8'hA0) begin failures++; $display("FAIL b2b_led_clr got=%h exp=a0", led0); end
      checks++;
      if ({rdy0, resp0, rdata0} !== {1'b1, 1'b0, 32'hA0}) begin
         failures++; $display("FAIL b2b_read rdy/resp/rdata got=%b/%b/%h exp=1/0/000000a0", rdy0, resp0, rdata0);
      end
      ap(1'b0, 32'h00, 1'b1, 3'b010);
      @(negedge clk); hwdata = 32'h3C; ap(1'b0, 32'h00, 1'b0, 3'b010);
      @(negedge clk);
      checks++;
      if (rdata0 !== 32'h3C) begin failures++; $display("FAIL raw_read got=%h exp=0000003c", rdata0); end
      idle();
   endtask

   task automatic test_wait_states();
      xfer(1'b1, 32'h04, 1'b1, 3'b010, 32'h01, 32'd0, 1'b0, 3, "ws3_set_write");
      @(negedge clk);
      checks++;
      if (led3 !== 8'h01) begin failures++; $display("FAIL ws3_led got=%h exp=01", led3); end
      xfer(1'b1, 32'h04, 1'b0, 3'b010, 32'd0, 32'd0, 1'b0, 3, "ws3_set_read");
      xfer(1'b1, 32'h00, 1'b0, 3'b010, 32'd0, 32'h01, 1'b0, 3, "ws3_led_read");
      xfer(1'b1, 32'h02, 1'b0, 3'b010, 32'd0, 32'd0, 1'b1, 1, "ws3_misaligned");
   endtask

   task automatic test_errors();
      xfer(1'b0, 32'h00, 1'b1, 3'b000, 32'hFF, 32'd0, 1'b1, 1, "err_byte_write");
      xfer(1'b0, 32'h18, 1'b0, 3'b010, 32'd0, 32'd0, 1'b1, 1, "err_range_read");
      xfer(1'b0, 32'h14, 1'b1, 3'b010, 32'h00, 32'd0, 1'b1, 1, "err_id_write");
      @(negedge clk);
      checks++;
      if (led0 !== 8'h3C) begin failures++; $display("FAIL err_led_unchanged got=%h exp=3c", led0); end
      ap(1'b0, 32'h18, 1'b0, 3'b010);
      @(negedge clk);
      checks++;
      if ({rdy0, resp0} !== 2'b01) begin failures++; $display("FAIL err1_phase rdy/resp got=%b/%b exp=0/1", rdy0, resp0); end
      idle();
      @(negedge clk);
      checks++;
      if ({rdy0, resp0} !== 2'b11) begin failures++; $display("FAIL err2_phase rdy/resp got=%b/%b exp=1/1", rdy0, resp0); end
      ap(1'b0, 32'h00, 1'b0, 3'b010);
      @(negedge clk);
      checks++;
      if ({rdy0, resp0, rdata0} !== {1'b1, 1'b0, 32'h3C}) begin
         failures++; $display("FAIL err2_pipelined_read rdy/resp/rdata got=%b/%b/%h exp=1/0/0000003c", rdy0, resp0, rdata0);
      end
      idle();
   endtask

   task automatic test_buttons();
      @(negedge clk); btn = 1'b1; ap(1'b0, 32'h0C, 1'b0, 3'b010);
      @(negedge clk);
      checks++;
      if (rdata0 !== 32'd0) begin failures++; $display("FAIL btn_sync_1edge got=%h exp=0", rdata0); end
      ap(1'b0, 32'h0C, 1'b0, 3'b010);
      @(negedge clk);
      checks++;
      if (rdata0 !== 32'd1) begin failures++; $display("FAIL btn_sync_2edge got=%h exp=1", rdata0); end
      ap(1'b0, 32'h10, 1'b0, 3'b010);
      @(negedge clk);
      checks++;
      if (rdata0 !== 32'd1) begin failures++; $display("FAIL btn_edge_set got=%h exp=1", rdata0); end
      idle();
      btn = 1'b0;
      repeat (4) @(negedge clk);
      xfer(1'b0, 32'h10, 1'b1, 3'b010, 32'h1, 32'd0, 1'b0, 0, "edge_w1c");
      xfer(1'b0, 32'h10, 1'b0, 3'b010, 32'd0, 32'd0, 1'b0, 0, "edge_cleared");
      @(negedge clk); btn = 1'b1;
      @(negedge clk); ap(1'b0, 32'h10, 1'b1, 3'b010);
      @(negedge clk); hwdata = 32'h1; ap(1'b0, 32'h10, 1'b0, 3'b010);
      @(negedge clk);
      checks++;
      if (rdata0 !== 32'd1) begin failures++; $display("FAIL edge_hw_wins got=%h exp=1", rdata0); end
      idle();
      xfer(1'b0, 32'h10, 1'b1, 3'b010, 32'h1, 32'd0, 1'b0, 0, "edge_w1c2");
      xfer(1'b0, 32'h10, 1'b0, 3'b010, 32'd0, 32'd0, 1'b0, 0, "edge_cleared2");
   endtask

   task automatic test_reset_mid_transfer();
      @(negedge clk); ap(1'b1, 32'h00, 1'b1, 3'b010);
      @(negedge clk); idle(); hwdata = 32'hFF;
      checks++;
      if (rdy3 !== 1'b0) begin failures++; $display("FAIL rst_mid_wait rdy got=%b exp=0", rdy3); end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({rdy3, resp3, led3} !== {1'b1, 1'b0, 8'h00}) begin
         failures++; $display("FAIL rst_mid_async rdy/resp/led got=%b/%b/%h exp=1/0/00", rdy3, resp3, led3);
      end
      @(negedge clk); rst = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      if ({rdy3, led3} !== {1'b1, 8'h00}) begin
         failures++; $display("FAIL rst_write_dropped rdy/led got=%b/%h exp=1/00", rdy3, led3);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_id();
      test_back_to_back();
      test_wait_states();
      test_errors();
      test_buttons();
      test_reset_mid_transfer();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
